// File: rtl/jacobi_rotation_engine.sv
// Givens rotation engine for the Jacobi eigen datapath.
// Rotates vectors p/q by (cos, sin) through a 3-stage multiply/round/clamp pipe.
module jacobi_rotation_engine #(
  parameter int ACC_WIDTH  = 20,
  parameter int N          = 4,
  parameter int LANES      = 1,
  parameter int TRIG_WIDTH = 16,
  parameter int FRAC_BITS  = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [N*ACC_WIDTH-1:0] vec_p,
  input  logic [N*ACC_WIDTH-1:0] vec_q,
  input  logic [TRIG_WIDTH-1:0]  sin_theta,
  input  logic [TRIG_WIDTH-1:0]  cos_theta,
  output logic                   busy,
  output logic                   done,
  output logic                   sat_flag,
  output logic [N*ACC_WIDTH-1:0] vec_p_new,
  output logic [N*ACC_WIDTH-1:0] vec_q_new
);

  localparam int W     = ACC_WIDTH;
  localparam int BEATS = N / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = ACC_WIDTH + TRIG_WIDTH;
  localparam int SW    = PW + 1;

  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  localparam logic signed [SW-1:0] RND =
    SW'(1) << (FRAC_BITS - 1);
  localparam logic signed [SW-1:0] MAXV =
    {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [N*W-1:0]                p_buf_q, q_buf_q;
  logic signed [TRIG_WIDTH-1:0]  sin_q, cos_q;
  logic                          mode_q;
  logic [BW-1:0]                 cnt_q;

  logic                          accept, issue;
  logic                          last_wr, done_d;

  logic                          v1_q, m1_q;
  logic [BW-1:0]                 b1_q;
  logic signed [PW-1:0]          cp1_q [LANES];
  logic signed [PW-1:0]          sq1_q [LANES];
  logic signed [PW-1:0]          cq1_q [LANES];
  logic signed [PW-1:0]          sp1_q [LANES];

  logic                          v2_q;
  logic [BW-1:0]                 b2_q;
  logic signed [SW-1:0]          pr2_q [LANES];
  logic signed [SW-1:0]          qr2_q [LANES];
  logic signed [SW-1:0]          pr2_d [LANES];
  logic signed [SW-1:0]          qr2_d [LANES];

  logic signed [W-1:0]           pe [LANES];
  logic signed [W-1:0]           qe [LANES];
  logic [W-1:0]                  pc [LANES];
  logic [W-1:0]                  qc [LANES];
  logic                          clip_any;

  logic                          done_q, sat_q;
  logic [N*W-1:0]                p_new_q, q_new_q;

  function automatic logic signed [PW-1:0] mul(
    input logic signed [TRIG_WIDTH-1:0] a,
    input logic signed [W-1:0]          b
  );
    logic signed [PW-1:0] ax, bx;
    ax = PW'(a);
    bx = PW'(b);
    return ax * bx;
  endfunction

  function automatic logic [W-1:0] clamp(
    input logic signed [SW-1:0] x
  );
    logic [W-1:0] r;
    if (x > MAXV)      r = MAXV[W-1:0];
    else if (x < MINV) r = MINV[W-1:0];
    else               r = x[W-1:0];
    return r;
  endfunction

  function automatic logic clipped(
    input logic signed [SW-1:0] x
  );
    return (x > MAXV) || (x < MINV);
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DRAIN;
      S_DRAIN: if (last_wr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: accept/issue strobes, busy and the done pulse source
  always_comb begin
    accept  = (state_q == S_IDLE) && start;
    issue   = (state_q == S_RUN);
    busy    = (state_q != S_IDLE);
    last_wr = v2_q && (b2_q == LAST);
    done_d  = (state_q == S_DRAIN) && last_wr;
  end

  // Operand buffers captured on accept; beat counter advances while issuing
  always_ff @(posedge clk) begin
    if (rst) begin
      p_buf_q <= '0;
      q_buf_q <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      p_buf_q <= vec_p;
      q_buf_q <= vec_q;
      sin_q   <= sin_theta;
      cos_q   <= cos_theta;
      mode_q  <= mode;
      cnt_q   <= '0;
    end else if (issue) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Select the lane operands of the current beat
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      pe[l] = p_buf_q[(int'(cnt_q)*LANES + l)*W +: W];
      qe[l] = q_buf_q[(int'(cnt_q)*LANES + l)*W +: W];
    end
  end

  // Stage 1: full-precision products
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      b1_q <= '0;
      m1_q <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        cp1_q[l] <= '0;
        sq1_q[l] <= '0;
        cq1_q[l] <= '0;
        sp1_q[l] <= '0;
      end
    end else begin
      v1_q <= issue;
      b1_q <= cnt_q;
      m1_q <= mode_q;
      for (int l = 0; l < LANES; l++) begin
        cp1_q[l] <= mul(cos_q, pe[l]);
        sq1_q[l] <= mul(sin_q, qe[l]);
        cq1_q[l] <= mul(cos_q, qe[l]);
        sp1_q[l] <= mul(sin_q, pe[l]);
      end
    end
  end

  // Stage 2 combine: sum/difference per mode, then round half up
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      if (m1_q) begin
        pr2_d[l] = SW'(cp1_q[l]) - SW'(sq1_q[l]);
        qr2_d[l] = SW'(sp1_q[l]) + SW'(cq1_q[l]);
      end else begin
        pr2_d[l] = SW'(cp1_q[l]) + SW'(sq1_q[l]);
        qr2_d[l] = SW'(cq1_q[l]) - SW'(sp1_q[l]);
      end
      pr2_d[l] = (pr2_d[l] + RND) >>> FRAC_BITS;
      qr2_d[l] = (qr2_d[l] + RND) >>> FRAC_BITS;
    end
  end

  // Stage 2 register
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
      b2_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        pr2_q[l] <= '0;
        qr2_q[l] <= '0;
      end
    end else begin
      v2_q <= v1_q;
      b2_q <= b1_q;
      for (int l = 0; l < LANES; l++) begin
        pr2_q[l] <= pr2_d[l];
        qr2_q[l] <= qr2_d[l];
      end
    end
  end

  // Stage 3 clamp to the element range and detect clipping
  always_comb begin
    clip_any = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      pc[l] = clamp(pr2_q[l]);
      qc[l] = clamp(qr2_q[l]);
      if (clipped(pr2_q[l]) || clipped(qr2_q[l]))
        clip_any = 1'b1;
    end
  end

  // Stage 3 write-back into the result vectors at the carried beat
  always_ff @(posedge clk) begin
    if (rst) begin
      p_new_q <= '0;
      q_new_q <= '0;
    end else if (v2_q) begin
      for (int l = 0; l < LANES; l++) begin
        p_new_q[(int'(b2_q)*LANES + l)*W +: W] <= pc[l];
        q_new_q[(int'(b2_q)*LANES + l)*W +: W] <= qc[l];
      end
    end
  end

  // Done pulse and sticky saturation flag (cleared by a new accept)
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      if (accept)
        sat_q <= 1'b0;
      else if (v2_q && clip_any)
        sat_q <= 1'b1;
    end
  end

  assign done      = done_q;
  assign sat_flag  = sat_q;
  assign vec_p_new = p_new_q;
  assign vec_q_new = q_new_q;

endmodule

// File: tb/tb_jacobi_rotation_engine.sv
// Directed bench for jacobi_rotation_engine.
// Hand-computed vectors; LANES=1 main instance plus a LANES=2 instance.
module tb_jacobi_rotation_engine;

  localparam int W = 20;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst, start, start2, mode;
  logic [N*W-1:0] vec_p, vec_q;
  logic [15:0]    sin_theta, cos_theta;
  logic           busy, done, sat;
  logic [N*W-1:0] p_new, q_new;
  logic           busy2, done2, sat2;
  logic [N*W-1:0] p_new2, q_new2;

  int checks = 0;
  int errors = 0;

  int P1[4]  = '{1, -2, 3, -4};
  int Q1[4]  = '{5, 6, 7, 8};
  int NP1[4] = '{-1, 2, -3, 4};
  int NQ1[4] = '{-5, -6, -7, -8};
  int P3[4]  = '{3, -3, 1, -1};
  int E3[4]  = '{2, -1, 1, 0};
  int Z[4]   = '{0, 0, 0, 0};
  int PS[4]  = '{524287, -524288, 0, 0};
  int J[4]   = '{99, 99, 99, 99};

  jacobi_rotation_engine #(
    .ACC_WIDTH(20), .N(4), .LANES(1),
    .TRIG_WIDTH(16), .FRAC_BITS(14)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .vec_p(vec_p), .vec_q(vec_q),
    .sin_theta(sin_theta), .cos_theta(cos_theta),
    .busy(busy), .done(done), .sat_flag(sat),
    .vec_p_new(p_new), .vec_q_new(q_new)
  );

  jacobi_rotation_engine #(
    .ACC_WIDTH(20), .N(4), .LANES(2),
    .TRIG_WIDTH(16), .FRAC_BITS(14)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode),
    .vec_p(vec_p), .vec_q(vec_q),
    .sin_theta(sin_theta), .cos_theta(cos_theta),
    .busy(busy2), .done(done2), .sat_flag(sat2),
    .vec_p_new(p_new2), .vec_q_new(q_new2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int c, input int s, input logic m,
                        input int p[4], input int q[4]);
    cos_theta = 16'(c);
    sin_theta = 16'(s);
    mode      = m;
    for (int i = 0; i < N; i++) begin
      vec_p[i*W +: W] = W'(p[i]);
      vec_q[i*W +: W] = W'(q[i]);
    end
  endtask

  function automatic longint el(input logic [N*W-1:0] v,
                                input int i);
    return longint'($signed(v[i*W +: W]));
  endfunction

  task automatic check_vecs(input string tag,
                            input logic [N*W-1:0] pv,
                            input logic [N*W-1:0] qv,
                            input int ep[4], input int eq[4]);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s p[%0d]", tag, i), el(pv, i), ep[i]);
      chk($sformatf("%s q[%0d]", tag, i), el(qv, i), eq[i]);
    end
  endtask

  task automatic run_op(input string tag, input int c, input int s,
                        input logic m, input int p[4], input int q[4],
                        input int ep[4], input int eq[4],
                        input logic esat);
    set_in(c, s, m, p, q);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy@0"}, busy, 1);
    chk({tag, " sat@0"}, sat, 0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("%s done@%0d", tag, e), done, 0);
      chk($sformatf("%s busy@%0d", tag, e), busy, 1);
    end
    tick();
    chk({tag, " done@6"}, done, 1);
    chk({tag, " busy@6"}, busy, 0);
    check_vecs(tag, p_new, q_new, ep, eq);
    chk({tag, " sat"}, sat, esat);
    tick();
    chk({tag, " done@7"}, done, 0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    set_in(0, 0, 1'b0, Z, Z);
    tick();
    tick();
    rst = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sat", sat, 0);
    check_vecs("rst", p_new, q_new, Z, Z);

    run_op("ident", 16384, 0, 1'b0, P1, Q1, P1, Q1, 1'b0);
    run_op("rot90m0", 0, 16384, 1'b0, P1, Q1, Q1, NP1, 1'b0);
    run_op("rot90m1", 0, 16384, 1'b1, P1, Q1, NQ1, P1, 1'b0);
    run_op("round", 8192, 0, 1'b0, P3, Z, E3, Z, 1'b0);
    run_op("sat", 16384, 16384, 1'b0, PS, PS, PS, Z, 1'b1);
    repeat (3) tick();
    chk("sat hold", sat, 1);
    check_vecs("hold", p_new, q_new, PS, Z);
    run_op("unsat", 16384, 0, 1'b0, P1, Q1, P1, Q1, 1'b0);

    // start held high: second accept 7 edges after the first
    set_in(16384, 0, 1'b0, P1, Q1);
    start = 1'b1;
    tick();
    set_in(123, 77, 1'b1, J, J);
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("b2b done@%0d", e), done, 0);
    end
    tick();
    chk("b2b done@6", done, 1);
    check_vecs("b2b A", p_new, q_new, P1, Q1);
    set_in(0, 16384, 1'b1, P1, Q1);
    tick();
    chk("b2b busy@7", busy, 1);
    chk("b2b done@7", done, 0);
    set_in(123, 77, 1'b0, J, J);
    for (int e = 8; e <= 12; e++) begin
      tick();
      chk($sformatf("b2b done@%0d", e), done, 0);
    end
    tick();
    start = 1'b0;
    chk("b2b done@13", done, 1);
    check_vecs("b2b B", p_new, q_new, NQ1, P1);
    tick();

    // two-lane instance finishes after 4 edges
    set_in(0, 16384, 1'b0, P1, Q1);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk($sformatf("l2 done@%0d", e), done2, 0);
    end
    tick();
    chk("l2 done@4", done2, 1);
    chk("l2 busy@4", busy2, 0);
    check_vecs("l2", p_new2, q_new2, Q1, NP1);
    tick();

    // reset in the middle of an operation
    set_in(16384, 0, 1'b0, P3, Q1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst busy", busy, 0);
    chk("mrst done", done, 0);
    chk("mrst sat", sat, 0);
    check_vecs("mrst", p_new, q_new, Z, Z);
    for (int e = 4; e <= 9; e++) begin
      tick();
      chk($sformatf("mrst done@%0d", e), done, 0);
      chk($sformatf("mrst busy@%0d", e), busy, 0);
    end
    run_op("post", 16384, 0, 1'b0, P3, Q1, P3, Q1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jacobi_rotation_engine.md
# jacobi_rotation_engine

Parametrised Givens rotation engine for the Jacobi eigen-decomposition datapath. It applies a fixed-point rotation (cos θ, sin θ) to two length-N vectors p and q, which are the p/q columns or the p/q rows of the working matrix. It processes LANES elements per cycle through a 3-stage pipeline, with round-half-up rescaling, output saturation and a sticky saturation flag. It sits between the angle-computation unit and the matrix/eigenvector storage, and serves both the right (column) and left (row) rotation passes.

## Interface
- ACC_WIDTH, 20: element width, signed two's complement.
- N, 4: vector length; N ≥ 2.
- LANES, 1: elements processed per beat; must divide N.
- TRIG_WIDTH, 16: signed width of sin/cos.
- FRAC_BITS, 14: fractional bits of sin/cos (1.0 = 2^FRAC_BITS); 1 ≤ FRAC_BITS < TRIG_WIDTH.
- Derived: BEATS = N/LANES.

Ports:
- clk  in  1  clock; sole clock domain, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- mode  in  1  0: p'=c·p+s·q, q'=c·q−s·p; 1: p'=c·p−s·q, q'=s·p+c·q.
- vec_p  in  ACC_WIDTH × [0:N-1]  p operand, signed.
- vec_q  in  ACC_WIDTH × [0:N-1]  q operand, signed.
- sin_theta  in  TRIG_WIDTH  signed sin.
- cos_theta  in  TRIG_WIDTH  signed cos.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; all outputs of the operation are valid.
- sat_flag  out  1  sticky; at least one element of the current or last operation saturated.
- vec_p_new  out  ACC_WIDTH × [0:N-1]  rotated p.
- vec_q_new  out  ACC_WIDTH × [0:N-1]  rotated q.

## Operation
- States:
  - IDLE: wait for start.
  - RUN: issue beats 0..BEATS-1, one per cycle.
  - DRAIN: wait for the pipeline to empty.
- Accept: on an edge where start=1 in IDLE, the engine does all of the following:
  - registers vec_p, vec_q, sin, cos and mode into internal buffers;
  - clears sat_flag;
  - sets busy=1;
  - sets beat counter=0;
  - moves to RUN.
- Inputs may change freely after the accept edge.
- start while busy=1 is ignored, with no queuing.
- RUN: each cycle issues elements [b·LANES, b·LANES+LANES-1] into stage 1. The counter increments each cycle. After the beat BEATS-1 issue the engine goes to DRAIN.
- Stage 1 (multiply): four products c·p, s·q, c·q, s·p, each of width ACC_WIDTH+TRIG_WIDTH, full precision, no truncation.
- Stage 2 (combine and round):
  - Form the sum or difference per mode at width ACC_WIDTH+TRIG_WIDTH+1.
  - Add 2^(FRAC_BITS-1), then shift right arithmetically by FRAC_BITS. This is round half toward +∞.
- Stage 3 (saturate and write):
  - Clamp to [−2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)−1].
  - Write to vec_p_new/vec_q_new at the carried element indices.
  - Set sat_flag if any lane clamped.
- Each pipeline stage carries a valid bit and the beat index. Output registers update only on a valid stage-3 write. Elements not yet written keep their previous values.
- DRAIN: on the edge that writes beat BEATS-1, the engine sets done=1 and busy=0 and returns to IDLE.
- Outputs and sat_flag hold until the next accepted operation overwrites them.
- rst=1 on any edge, including mid-operation:
  - state returns to IDLE;
  - the beat counter clears;
  - all valid bits clear and in-flight beats are discarded;
  - busy=0, done=0, sat_flag=0;
  - every element of vec_p_new and vec_q_new is 0.
- rst has priority over start.

## Timing
- Numbering: accept edge = edge 0.
- Beat b enters stage 1 at edge b+1 and stage 2 at edge b+2, and is written to the outputs at edge b+3.
- done rises at edge BEATS+2, the same edge as the final write, and is high for exactly one cycle.
- busy is high from edge 0 through edge BEATS+2, when it falls.
- start high while done=1 (busy=0) is accepted, giving back-to-back operations every BEATS+3 cycles.
- Per-operation latency, accept to done: BEATS+2 cycles. For N=4: LANES=1 → 6; LANES=2 → 4; LANES=4 → 3.
- No combinational path from any input to any output.

## Test plan
All scenarios use N=4, ACC_WIDTH=20, TRIG_WIDTH=16, FRAC_BITS=14, LANES=1 unless noted.

1. Identity: cos=16384, sin=0, mode=0, p=[1,−2,3,−4], q=[5,6,7,8] → outputs unchanged; done at edge 6 only; busy high for edges 0–5; sat_flag=0.
2. 90° both modes: cos=0, sin=16384, same p and q:
   - mode=0 → p'=[5,6,7,8], q'=[−1,2,−3,4];
   - mode=1 → p'=[−5,−6,−7,−8], q'=[1,−2,3,−4].
3. Rounding: cos=8192, sin=0, p=[3,−3,1,−1], q=[0,0,0,0] → p'=[2,−1,1,0], q'=[0,0,0,0].
4. Saturation: p=q=[524287,−524288,0,0], cos=sin=16384, mode=0 → p'=[524287,−524288,0,0], q'=[0,0,0,0], sat_flag=1. A following in-range operation clears sat_flag at accept.
5. Handshake:
   - start held high continuously → a new accept every 7 cycles, with second-operation data taken only at its accept edge;
   - LANES=2 build → done at edge 4 with identical results to scenario 2.
6. Reset mid-operation: rst=1 at edge 3 → busy=0, done never pulses, all outputs 0. A fresh start after reset → correct results at edge 6 of the new operation.
